// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//   Streams a program into the instruction RAM write port, one 32-bit word per
//   address starting at 0. Any location above the last program word is padded
//   with FILL_WORD (normally the LC2K halt encoding). The CPU is held with
//   cpu_hold until the whole image has been written.
//
// Handshake:
//   A word is accepted on a rising edge where word_valid & word_ready are both
//   high. word_ready depends only on the FSM state (high in LOAD only), never
//   on word_valid, so the source may hold word_valid high for as long as it
//   likes. The accepted word appears on the RAM write port one cycle later.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             one-cycle pulse, begins a new load (ignored in LOAD/FILL)
//   word_in           program word
//   word_valid        word_in valid
//   word_last         marks word_in as the final program word
//   word_ready        loader can accept a word this cycle
//   wr_en             instruction RAM write strobe
//   wr_addr           instruction RAM write address
//   wr_data           instruction RAM write data
//   cpu_hold          1 = CPU held (PC frozen at 0)
//   done              image fully written
//   error             image overflowed DEPTH
//   word_count        program words accepted in the current load
//   checksum          (IMEM_LOADER_CHECKSUM_EN only) mod-2^32 sum of the
//                     accepted program words, fill words excluded
//   state_dbg         current FSM state encoding, for observation only
//
// Configuration:
//   Define IMEM_LOADER_CHECKSUM_EN to add the checksum output.
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int          DEPTH     = 16,
    parameter int          ADDR_W    = 4,
    parameter logic [31:0] FILL_WORD = 32'd25165824
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       word_in,
    input  logic              word_valid,
    input  logic              word_last,
    output logic              word_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic [2:0]        state_dbg
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FILL  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    // addr_q carries one extra bit so it can hold DEPTH itself. That value
    // means "every location has been issued" and is never driven onto wr_addr.
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] END_ADDR  = (ADDR_W+1)'(DEPTH);

    logic [2:0]        state_q,   state_d;
    logic [ADDR_W:0]   addr_q,    addr_d;
    logic [ADDR_W:0]   count_q,   count_d;
    logic              ovf_q,     ovf_d;
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       csum_q,    csum_d;
`endif

    logic accept;

    assign accept = (state_q == S_LOAD) && word_valid;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                // A word presented alongside start is not taken: word_ready is
                // low in these states, acceptance only begins in LOAD.
                if (start) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end

            S_LOAD: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q[ADDR_W-1:0];
                    wr_data_d = word_in;
                    addr_d    = addr_q + 1'b1;
                    count_d   = count_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d    = csum_q + word_in;
`endif
                    if (addr_q == LAST_ADDR) begin
                        // Top location taken. addr_d is now END_ADDR, so FILL
                        // issues no writes and only spends the cycle in which
                        // this final write is on the port; ovf selects whether
                        // that drain lands in ERROR or DONE.
                        state_d = S_FILL;
                        ovf_d   = ~word_last;
                    end else if (word_last) begin
                        state_d = S_FILL;
                    end
                end
            end

            S_FILL: begin
                if (addr_q != END_ADDR) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q[ADDR_W-1:0];
                    wr_data_d = FILL_WORD;
                    addr_d    = addr_q + 1'b1;
                end else begin
                    // The write to DEPTH-1 is visible this cycle; the final
                    // status is reported from the next cycle on.
                    state_d = ovf_q ? S_ERROR : S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // Status flags decode the state directly, so they change in the same
    // cycle the state does (e.g. done drops the cycle LOAD is entered).
    assign word_ready = (state_q == S_LOAD);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERROR);
    assign cpu_hold   = (state_q != S_DONE);

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign word_count = count_q;
    assign state_dbg  = state_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign checksum   = csum_q;
`endif

endmodule
